pong_game_ctrl: RTL
===================

// Module: pong_game_ctrl
// PURPOSE
//  Top-level Pong game sequencer. Owns the two BCD score counters (left, right):
//  drives their increment/clear strobes, reads back their digits for win detection,
//  times serve and point pauses in frame ticks, and gates the ball datapath.
//  Sits between the ball/paddle logic (miss events) and the score/text renderers.
// PARAMETERS
//  WIN_SCORE     11   points (binary, 1..99) that end the game
//  SERVE_TICKS   120  frame ticks ball is held at centre before play (1..255)
//  POINT_TICKS   60   frame ticks of pause after a point (1..255)
// PORTS
//  clk         in   1  system clock
//  reset_n     in   1  async active-low reset
//  tick        in   1  one-cycle frame strobe (60 Hz)
//  btn_start   in   1  start button, synchronous, debounced level
//  miss_l      in   1  one-cycle pulse: ball passed left paddle (right scores)
//  miss_r      in   1  one-cycle pulse: ball passed right paddle (left scores)
//  l_dig1/l_dig0 in 4  left score counter BCD tens/ones
//  r_dig1/r_dig0 in 4  right score counter BCD tens/ones
//  inc_l       out  1  increment strobe to left score counter
//  inc_r       out  1  increment strobe to right score counter
//  clr         out  1  clear strobe to both score counters
//  ball_en     out  1  ball motion enable
//  ball_rst    out  1  hold ball at centre
//  serve_dir   out  1  0 = serve toward left, 1 = toward right
//  game_over   out  1  game finished, winner valid
//  winner      out  1  0 = left, 1 = right; valid while game_over
// BEHAVIOUR
//  - All outputs registered. On reset_n low: state IDLE, timer 0, all outputs 0.
//  - Start edge = btn_start high this cycle, low previous cycle (internal reg, resets 0).
//  - States / transitions (evaluated each clk):
//    IDLE : ball_rst=1. Start edge -> CLEAR.
//    CLEAR: exactly 1 cycle; clr=1, serve_dir=0, winner=0 -> SERVE, timer=0.
//    SERVE: ball_rst=1. Timer +1 per tick; at tick with timer==SERVE_TICKS-1 -> PLAY.
//    PLAY : ball_en=1. miss_l only -> POINT, inc_r=1 (one cycle), serve_dir=0.
//           miss_r only -> POINT, inc_l=1, serve_dir=1.
//           miss_l & miss_r same cycle -> POINT, no increment (replay), serve_dir kept.
//    POINT: ball_rst=1, timer counts ticks; at tick with timer==POINT_TICKS-1:
//           left score >= WIN_SCORE -> OVER, winner=0; else right >= WIN_SCORE ->
//           OVER, winner=1; else -> SERVE, timer=0.
//    OVER : game_over=1, ball_rst=1, winner held. Start edge -> CLEAR.
//  - Strobe timing: miss sampled cycle N -> inc_x high cycle N+1 only -> counter
//    updates at edge N+2. Win check occurs >=1 tick later, so digits are settled.
//  - Score value = dig1*10 + dig0 (7-bit). Counters wrap 99->0; WIN_SCORE<=99 so
//    wrap is unreachable in normal play.
//  - miss pulses outside PLAY ignored; btn_start ignored outside IDLE/OVER.
//  - Timer is 8 bits, cleared on every state entry; ticks outside SERVE/POINT ignored.
//  - inc_l, inc_r, clr mutually exclusive; never high more than 1 consecutive cycle.
//  - reset_n asserted in any state (incl. mid-pause or during a strobe) -> IDLE,
//    all strobes drop immediately; scores cleared only by next CLEAR.
// TESTING
//  1 reset, btn_start edge -> clr high exactly 1 cycle; SERVE; ball_en=1 after 120 ticks.
//  2 PLAY, miss_r pulse -> inc_l high 1 cycle next clk, serve_dir=1; SERVE after 60 ticks.
//  3 left digits 1/1 at POINT expiry (WIN_SCORE=11) -> game_over=1, winner=0, ball_en=0.
//  4 miss_l & miss_r same cycle -> no inc strobes, POINT then SERVE, serve_dir unchanged.
//  5 btn_start held high through OVER->CLEAR->SERVE -> single clr, no restart loop.
//  6 reset_n low mid-SERVE with timer=50 -> all outputs 0 async; start edge -> clean CLEAR.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong sequencer - serve/point pacing, score strobes, win detection and ball gating.
module pong_game_ctrl #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_TICKS = 120,
  parameter int POINT_TICKS = 60
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tick,
  input  logic       i_btn_start,
  input  logic       i_miss_l,
  input  logic       i_miss_r,
  input  logic [3:0] i_l_dig1,
  input  logic [3:0] i_l_dig0,
  input  logic [3:0] i_r_dig1,
  input  logic [3:0] i_r_dig0,
  output logic       o_inc_l,
  output logic       o_inc_r,
  output logic       o_clr,
  output logic       o_ball_en,
  output logic       o_ball_rst,
  output logic       o_serve_dir,
  output logic       o_game_over,
  output logic       o_winner
);
  typedef enum logic [2:0] {IDLE, CLEAR, SERVE, PLAY, POINT, OVER} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_timer;
  logic       r_btn_d;
  logic       w_start, w_l_only, w_r_only, w_l_win, w_r_win;
  logic [6:0] w_l_score, w_r_score;
  assign w_start   = i_btn_start & ~r_btn_d;
  assign w_l_only  = (r_state == PLAY) & i_miss_l & ~i_miss_r;
  assign w_r_only  = (r_state == PLAY) & i_miss_r & ~i_miss_l;
  assign w_l_score = {3'd0, i_l_dig1} * 7'd10 + {3'd0, i_l_dig0};
  assign w_r_score = {3'd0, i_r_dig1} * 7'd10 + {3'd0, i_r_dig0};
  assign w_l_win   = w_l_score >= 7'(WIN_SCORE);
  assign w_r_win   = w_r_score >= 7'(WIN_SCORE);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, OVER: w_next = w_start ? CLEAR : r_state;
      CLEAR:      w_next = SERVE;
      SERVE:      w_next = (i_tick && r_timer == 8'(SERVE_TICKS - 1)) ? PLAY : SERVE;
      PLAY:       w_next = (i_miss_l | i_miss_r) ? POINT : PLAY;
      POINT:      w_next = (i_tick && r_timer == 8'(POINT_TICKS - 1)) ? ((w_l_win | w_r_win) ? OVER : SERVE) : POINT;
      default:    w_next = IDLE;
    endcase
  end
  // Outputs are decoded from the state being entered so they line up with r_state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_timer     <= 8'd0;
      r_btn_d     <= 1'b0;
      o_inc_l     <= 1'b0;
      o_inc_r     <= 1'b0;
      o_clr       <= 1'b0;
      o_ball_en   <= 1'b0;
      o_ball_rst  <= 1'b0;
      o_serve_dir <= 1'b0;
      o_game_over <= 1'b0;
      o_winner    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_btn_d     <= i_btn_start;
      r_timer     <= (w_next != r_state) ? 8'd0 :
                     (i_tick && (r_state == SERVE || r_state == POINT)) ? r_timer + 8'd1 : r_timer;
      o_inc_l     <= w_r_only;
      o_inc_r     <= w_l_only;
      o_clr       <= w_next == CLEAR;
      o_ball_en   <= w_next == PLAY;
      o_ball_rst  <= w_next == IDLE || w_next == SERVE || w_next == POINT || w_next == OVER;
      o_game_over <= w_next == OVER;
      o_serve_dir <= (w_next == CLEAR || w_l_only) ? 1'b0 : w_r_only ? 1'b1 : o_serve_dir;
      o_winner    <= (w_next == CLEAR) ? 1'b0 : (r_state == POINT && w_next == OVER) ? ~w_l_win : o_winner;
    end
  end
endmodule
